cipher_out_serializer: RTL and testbench
========================================

CIPHER_OUT_SERIALIZER -- requirements
Module: cipher_out_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the number of 128-bit ciphertext blocks buffered; legal values are 2 and 4.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate that in_data holds a ciphertext block from the last AES round stage.
REQ-005 in_data  input  128  SHALL carry the ciphertext block (final round output).
REQ-006 in_ready  output  1  SHALL indicate that a block can be accepted this cycle.
REQ-007 out_valid  output  1  SHALL indicate that out_data holds a valid byte.
REQ-008 out_data  output  8  SHALL carry the current ciphertext byte.
REQ-009 out_ready  input  1  SHALL indicate that the byte sink accepts out_data this cycle.
REQ-010 out_last  output  1  SHALL mark the 16th (final) byte of a block.
REQ-011 busy  output  1  SHALL be high while the FIFO is non-empty or the serializer is in SEND.

Function
REQ-012 A block SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-013 in_ready SHALL equal (FIFO count < FIFO_DEPTH), registered-state only; it SHALL have no combinational path from out_ready.
REQ-014 The FIFO SHALL use read/write pointers that wrap modulo FIFO_DEPTH, plus a count from 0 to FIFO_DEPTH; a simultaneous push and pop SHALL leave the count unchanged.
REQ-015 The serializer FSM SHALL have exactly two states, IDLE and SEND.
REQ-016 IDLE with FIFO non-empty SHALL pop the head block into a 128-bit shift register, clear the 4-bit byte counter, and enter SEND on the same edge.
REQ-017 In SEND, out_valid SHALL be 1 and out_data SHALL equal shift register bits [127:120]; byte order SHALL be in_data[127:120] first and in_data[7:0] last.
REQ-018 On out_valid and out_ready, the shift register SHALL shift left by 8 and the byte counter SHALL increment.
REQ-019 out_last SHALL be high exactly when the FSM is in SEND and the byte counter is 15.
REQ-020 While out_valid is high and out_ready is low, out_data, out_last and the byte counter SHALL hold.
REQ-021 When byte 15 is accepted: if the FIFO is non-empty, the next block SHALL load on the same edge (zero bubble); otherwise the FSM SHALL return to IDLE.
REQ-022 Latency: a block accepted into an empty FIFO with the FSM in IDLE at edge E0 SHALL produce out_valid after edge E1.
REQ-023 Sustained throughput with out_ready held high SHALL be 16 bytes in 16 cycles per block.

Reset
REQ-024 Asserting reset SHALL immediately set the following, regardless of operation in progress: FSM=IDLE, pointers=0, count=0, byte counter=0, shift register=0.
REQ-025 During reset, outputs SHALL be out_valid=0, out_data=0, out_last=0, busy=0 and in_ready=0; in_ready SHALL rise in the first cycle after reset deasserts.
REQ-026 Blocks buffered or partially sent when reset asserts SHALL be discarded, and no further bytes from them SHALL be emitted.

Configuration
REQ-027 With macro CIPHER_OUT_PARITY_EN defined, the block SHALL add output out_parity (1 bit), equal to the XOR of out_data bits (even parity) and valid whenever out_valid is high; it SHALL be 0 under reset.
REQ-028 Without CIPHER_OUT_PARITY_EN defined, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then push 0x000102030405060708090A0B0C0D0E0F with out_ready=1 -> bytes 0x00..0x0F are emitted on 16 consecutive cycles, out_last is high only on 0x0F, and the first out_valid appears one edge after acceptance.
REQ-030 Push two blocks back-to-back with out_ready=1 -> 32 consecutive valid bytes with no gap, and out_last is high on bytes 16 and 32.
REQ-031 FIFO_DEPTH=2, out_ready=0, push 3 blocks -> block 1 loads into the shift register and blocks 2 and 3 fill the FIFO; in_ready=0 and a 4th block is stalled; releasing out_ready -> all 48 bytes are emitted in order.
REQ-032 Toggle out_ready randomly, 50% duty, on block 0xFFEEDDCCBBAA99887766554433221100 -> out_data holds while stalled, and the sequence 0xFF..0x00 is emitted complete and in order.
REQ-033 Assert reset after byte 5 of a block with one more block queued -> out_valid drops at once, busy=0, and after release no stale bytes are emitted.
REQ-034 With CIPHER_OUT_PARITY_EN defined, byte 0x07 -> out_parity=1 and byte 0x03 -> out_parity=0.

Source files
------------

// File: rtl/cipher_out_serializer_if.sv
// cipher_out_serializer_if: block-in / byte-out handshake bundle.
// out_parity exists only when CIPHER_OUT_PARITY_EN is defined.
interface cipher_out_serializer_if;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready;
  logic         out_last;
  logic         busy;
`ifdef CIPHER_OUT_PARITY_EN
  logic         out_parity;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_last, busy, out_parity
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_last, busy, out_parity
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_last, busy
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_last, busy
  );
`endif
endinterface

// File: rtl/cipher_out_serializer.sv
// cipher_out_serializer: FIFO of 128-bit blocks, sent MSB byte first.
// Optional even-parity output enabled by CIPHER_OUT_PARITY_EN.
module cipher_out_serializer #(
  parameter int FIFO_DEPTH = 2
) (
  input logic clock,
  input logic reset,
  cipher_out_serializer_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nxt;
  logic [127:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [127:0] sr;
  logic [3:0] bcnt;
  logic rdy;
  logic push, pop, take, done, nonempty;

  assign nonempty = (count != '0);
  assign take = (state == SEND) && bus.out_ready;
  assign done = take && (bcnt == 4'hF);
  assign push = bus.in_valid && bus.in_ready;
  assign pop = nonempty && ((state == IDLE) || done);

  // rdy keeps in_ready low through reset and for no longer
  assign bus.in_ready = rdy && (count < DEPTH_C);
  assign bus.out_data = sr[127:120];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (nonempty) state_nxt = SEND;
      SEND: if (done && !nonempty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last = 1'b0;
    bus.busy = nonempty;
    if (state == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_last = (bcnt == 4'hF);
      bus.busy = 1'b1;
    end
  end

`ifdef CIPHER_OUT_PARITY_EN
  assign bus.out_parity = bus.out_valid & (^sr[127:120]);
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= bus.in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      sr <= '0;
      bcnt <= '0;
      rdy <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (push) wptr <= (wptr == LAST_P) ? '0 : wptr + PW'(1);
      if (pop) rptr <= (rptr == LAST_P) ? '0 : rptr + PW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      // a pop reloads the shifter on the same edge that finishes a block
      if (pop) begin
        sr <= mem[rptr];
        bcnt <= '0;
      end else if (take) begin
        sr <= {sr[119:0], 8'h00};
        bcnt <= bcnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_cipher_out_serializer.sv
// tb_cipher_out_serializer: directed scenario tasks for the serializer.
// Default build; parity scenario runs when CIPHER_OUT_PARITY_EN is set.
module tb_cipher_out_serializer;
  logic clock;
  logic reset;
  int checks;
  int errors;

  cipher_out_serializer_if bus();

  cipher_out_serializer #(.FIFO_DEPTH(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] make_blk(input logic [7:0] base);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = base + 8'(i);
    return b;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_last !== 1'b0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h l=%b b=%b r=%b exp 0 00 0 0 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.busy,
               bus.in_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data = make_blk(8'h00);
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_in_ready got %b exp 1", bus.in_ready);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early got %b exp 0", bus.out_valid);
    end
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i) ||
          bus.out_last !== (i == 15)) begin
        errors++;
        $display("FAIL single_byte%0d got v=%b d=%h l=%b exp 1 %h %b",
                 i, bus.out_valid, bus.out_data, bus.out_last,
                 8'(i), (i == 15));
      end
      @(negedge clock);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got v=%b b=%b exp 0 0",
               bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data = make_blk(8'h10);
    bus.out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready);
    end
    bus.in_data = make_blk(8'h20);
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h10 + i) ||
          bus.out_last !== (i == 15 || i == 31)) begin
        errors++;
        $display("FAIL b2b_byte%0d got v=%b d=%h l=%b exp 1 %h %b",
                 i, bus.out_valid, bus.out_data, bus.out_last,
                 8'(8'h10 + i), (i == 15 || i == 31));
      end
      @(negedge clock);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got v=%b b=%b exp 0 0",
               bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_fifo_full();
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = make_blk(8'h30);
    @(negedge clock);
    bus.in_data = make_blk(8'h40);
    @(negedge clock);
    bus.in_data = make_blk(8'h50);
    @(negedge clock);
    bus.in_data = make_blk(8'h60);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_data !== 8'h30 || bus.out_last !== 1'b0) begin
        errors++;
        $display("FAIL full_stall%0d got r=%b v=%b d=%h l=%b exp 0 1 30 0",
                 k, bus.in_ready, bus.out_valid, bus.out_data,
                 bus.out_last);
      end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h30 + i) ||
          bus.out_last !== ((i % 16) == 15)) begin
        errors++;
        $display("FAIL full_byte%0d got v=%b d=%h l=%b exp 1 %h %b",
                 i, bus.out_valid, bus.out_data, bus.out_last,
                 8'(8'h30 + i), ((i % 16) == 15));
      end
      @(negedge clock);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_idle got v=%b b=%b exp 0 0",
               bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_random_stall();
    int idx;
    int cyc;
    logic r;
    logic [7:0] exp_d;
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 128'hFFEEDDCCBBAA99887766554433221100;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      exp_d = 8'hFF - 8'(8'h11 * idx);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d ||
          bus.out_last !== (idx == 15)) begin
        errors++;
        $display("FAIL stall_byte%0d got v=%b d=%h l=%b exp 1 %h %b",
                 idx, bus.out_valid, bus.out_data, bus.out_last,
                 exp_d, (idx == 15));
      end
      r = 1'($urandom_range(0, 1));
      bus.out_ready = r;
      @(negedge clock);
      if (r) idx++;
      cyc++;
    end
    checks++;
    if (idx != 16) begin
      errors++;
      $display("FAIL stall_timeout got %0d bytes exp 16", idx);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle got v=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    @(negedge clock);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = make_blk(8'h70);
    @(negedge clock);
    bus.in_data = make_blk(8'h80);
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h70 + i)) begin
        errors++;
        $display("FAIL rstmid_byte%0d got v=%b d=%h exp 1 %h",
                 i, bus.out_valid, bus.out_data, 8'(8'h70 + i));
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async got v=%b b=%b r=%b d=%h exp 0 0 0 00",
               bus.out_valid, bus.busy, bus.in_ready, bus.out_data);
    end
    @(negedge clock);
    reset = 1'b0;
    stale = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clock);
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rstmid_stale got %0d valid cycles exp 0", stale);
    end
    bus.in_valid = 1'b1;
    bus.in_data = make_blk(8'h90);
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h90 + i)) begin
        errors++;
        $display("FAIL rstmid_fresh%0d got v=%b d=%h exp 1 %h",
                 i, bus.out_valid, bus.out_data, 8'(8'h90 + i));
      end
      @(negedge clock);
    end
  endtask

`ifdef CIPHER_OUT_PARITY_EN
  task automatic test_parity();
    logic [127:0] b;
    b = make_blk(8'h00);
    b[127:120] = 8'h07;
    b[119:112] = 8'h03;
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = b;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.out_data !== 8'h07 || bus.out_parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_07 got d=%h p=%b exp 07 1",
               bus.out_data, bus.out_parity);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.out_data !== 8'h03 || bus.out_parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_03 got d=%h p=%b exp 03 0",
               bus.out_data, bus.out_parity);
    end
    repeat (16) @(negedge clock);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_random_stall();
    test_reset_mid();
`ifdef CIPHER_OUT_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
